y_update_engine: RTL and testbench
==================================

# y_update_engine

Parametrised Y-matrix update engine. It accepts queued branch-change records (row, col, complex ΔY) through a valid/ready FIFO and applies each record to the Y SRAM by read-modify-write: Y[r][r]+=ΔY, Y[c][c]+=ΔY, Y[r][c]−=ΔY, Y[c][r]−=ΔY. It sits between the change-file reader and the Y SRAM, and shares the external floating-point add/sub unit.

## Interface
- FW, 24, width of one real or imaginary floating-point value; one complex entry is 2*FW bits, real in the upper FW bits.
- N, 1024, matrix dimension; must be a multiple of LANES.
- LANES, 4, complex entries per SRAM word; power of two.
- IDX_W, 16, width of row/col indices.
- ADDR_W, 18, SRAM address width; must be ≥ clog2(N*N/LANES).
- DEPTH, 8, record FIFO depth; power of two.
- FP_LAT, 1, FP unit latency in cycles (1..4).

Ports:
- clock  in  1  the single clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  when low, no new record is popped; an in-flight record still completes.
- in_valid / in_ready  in/out  1  record handshake; transfer occurs when both are high.
- in_row, in_col  in  IDX_W  record indices.
- in_real, in_img  in  FW  ΔY components.
- in_remove  in  1  1 means branch removal; inverts every add/sub for that record.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_rd  out  1  read strobe.
- mem_rdata  in  LANES*2*FW  read word, valid the cycle after mem_rd; lane k is bits [k*2FW +: 2FW].
- mem_we  out  1  write strobe.
- mem_wdata  out  2*FW  new entry.
- mem_lane_oh  out  LANES  one-hot lane select, qualified by mem_we.
- fp_in1, fp_in2  out  FW  FP operands.
- fp_mode  out  1  0 = in1+in2, 1 = in1−in2.
- fp_out  in  FW  FP result, valid FP_LAT cycles after issue.
- busy  out  1  FSM not in IDLE.
- idle  out  1  FIFO empty and FSM IDLE.
- rec_done  out  1  one-cycle pulse after a record's last write.
- err_range  out  1  one-cycle pulse when a record is dropped.
- rec_count  out  16  count of records applied (dropped records excluded); wraps at 16 bits.

## Operation
- FIFO: in_ready = !full. A push while full is impossible, because in_ready is low even if a pop occurs in the same cycle. Records are applied strictly in FIFO order.
- FSM states: IDLE, POP, RD, RDW, FPR, FPI, FPW, WR.
- IDLE→POP when FIFO is non-empty and enable=1.
- POP: latch the record.
  - If row≥N or col≥N: pulse err_range and return to IDLE with no memory access.
  - Otherwise build the target list. For row≠col the list is (r,r),(c,c),(r,c),(c,r), in that order. For row==col (shunt) it is only (r,r).
- Per target (t,u):
  - addr = t*(N/LANES) + (u>>log2(LANES)); lane = u mod LANES.
  - RD: mem_rd=1, mem_addr=addr.
  - RDW: latch lane entry from mem_rdata.
  - FPR: issue real, fp_in1=old real, fp_in2=ΔY real.
  - FPI: issue imag.
  - FPW: wait until the imag result is captured.
  - WR: mem_we=1, mem_wdata={real result, imag result}, mem_lane_oh=1<<lane.
  - After WR: go to RD for the next target, or, if that was the last target, pulse rec_done, increment rec_count and go to IDLE.
- fp_mode: 0 for diagonal targets, 1 for off-diagonal targets; XOR with in_remove.
- Outside FPR/FPI, fp_in1, fp_in2 and fp_mode hold 0. mem_addr holds its last value. mem_rd, mem_we and mem_lane_oh are 0 outside RD and WR respectively.

## Timing
- Reset values: in_ready=0 during reset and 1 after, since the FIFO is empty. busy=0, idle=1, all strobes 0, mem_addr=0, mem_wdata=0, mem_lane_oh=0, fp_* =0, rec_count=0, FIFO empty.
- Reset asserted mid-record aborts the record immediately. No write is issued in any cycle where reset=1, and FIFO contents are discarded.
- For a target whose RD is at cycle t:
  - real result sampled at t+2+FP_LAT.
  - imag result sampled at t+3+FP_LAT.
  - WR at t+4+FP_LAT.
  - Each target takes 5+FP_LAT cycles.
- Record latency, measured from the POP cycle to the rec_done cycle:
  - 1 + 4*(5+FP_LAT) cycles; 25 for FP_LAT=1.
  - 1 + (5+FP_LAT) cycles for a shunt record.
- Back-to-back records: IDLE costs one cycle between rec_done and the next POP.
- enable dropped mid-record: the record finishes; the FSM then stays in IDLE with busy=0 and idle=0 if the FIFO is non-empty.
- Each record performs a single read/write per word access. Writes complete before the next read, so a later target reading an earlier target's word sees the updated value.

## Test plan
- Reset, then push (row=2, col=5, ΔY=1.0+j0.5, remove=0) into an SRAM preloaded with all 1.0+j1.0:
  - Y[2][2] and Y[5][5] become 2.0+j1.5; Y[2][5] and Y[5][2] become 0.0+j0.5.
  - rec_done fires 25 cycles after POP with FP_LAT=1; rec_count=1.
- Push the same record with remove=1: the four entries are restored to 1.0+j1.0.
- Shunt record (row=col=7): only one RD/WR pair occurs; mem_lane_oh=4'b1000; rec_done arrives 7 cycles after POP.
- Push 9 records with enable=0 and DEPTH=8: in_ready drops after the 8th push. Raise enable: all 8 are applied in order and idle returns high.
- Record with row=N: err_range pulses, mem_rd and mem_we never assert, rec_count is unchanged. Then assert reset during FPW of a valid record: no write occurs and all outputs return to their reset values.

Source files
------------

// File: rtl/y_update_engine_if.sv
// Bus bundle for y_update_engine.
// Groups the record input handshake, the Y SRAM port and the shared FP add/sub port.
//   in_*      : branch-change record stream (valid/ready)
//   mem_*     : Y SRAM word port (read data one cycle after mem_rd, lane-masked write)
//   fp_*      : external FP add/sub unit (result FP_LAT cycles after issue)
// master = the update engine, slave = the surrounding system (reader, SRAM, FP unit).
interface y_update_engine_if #(
    parameter int FW     = 24,
    parameter int LANES  = 4,
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 18
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IDX_W-1:0]          in_row;
    logic [IDX_W-1:0]          in_col;
    logic [FW-1:0]             in_real;
    logic [FW-1:0]             in_img;
    logic                      in_remove;

    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_rd;
    logic [LANES*2*FW-1:0]     mem_rdata;
    logic                      mem_we;
    logic [2*FW-1:0]           mem_wdata;
    logic [LANES-1:0]          mem_lane_oh;

    logic [FW-1:0]             fp_in1;
    logic [FW-1:0]             fp_in2;
    logic                      fp_mode;
    logic [FW-1:0]             fp_out;

    modport master (
        input  in_valid, in_row, in_col, in_real, in_img, in_remove,
        output in_ready,
        output mem_addr, mem_rd, mem_we, mem_wdata, mem_lane_oh,
        input  mem_rdata,
        output fp_in1, fp_in2, fp_mode,
        input  fp_out
    );

    modport slave (
        output in_valid, in_row, in_col, in_real, in_img, in_remove,
        input  in_ready,
        input  mem_addr, mem_rd, mem_we, mem_wdata, mem_lane_oh,
        output mem_rdata,
        input  fp_in1, fp_in2, fp_mode,
        output fp_out
    );
endinterface

// File: rtl/y_update_engine.sv
// Y-matrix update engine.
// Pops branch-change records (row, col, dY) from a small FIFO and applies them to the
// Y SRAM by read-modify-write through the shared FP add/sub unit:
//   Y[r][r] += dY, Y[c][c] += dY, Y[r][c] -= dY, Y[c][r] -= dY  (signs flip on removal)
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   enable       : gates popping of new records only
//   bus          : record handshake, SRAM port and FP port (y_update_engine_if.master)
//   busy / idle  : FSM active / FIFO empty and FSM idle
//   rec_done     : one-cycle pulse after the last write of a record
//   err_range    : one-cycle pulse when a record with an out-of-range index is dropped
//   rec_count    : applied-record count, wraps at 16 bits
//
// state | meaning
// IDLE  | waiting for a queued record and enable
// POP   | latch FIFO head, range check, address first target
// RD    | SRAM read strobe for current target
// RDW   | capture lane entry, set up real-part FP operands
// FPR   | real part issued to FP unit
// FPI   | imag part issued to FP unit
// FPW   | wait for the imag result (FP_LAT cycles)
// WR    | lane-masked write of the new entry
module y_update_engine #(
    parameter int FW     = 24,
    parameter int N      = 1024,
    parameter int LANES  = 4,
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 8,
    parameter int FP_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    y_update_engine_if.master    bus,
    output logic                 busy,
    output logic                 idle,
    output logic                 rec_done,
    output logic                 err_range,
    output logic [15:0]          rec_count
);
    localparam int EW    = 2 * FW;
    localparam int LOG2L = $clog2(LANES);
    localparam int WPR   = N / LANES;
    localparam int PW    = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [32:0]    N_EXT    = 33'(N);
    localparam logic [2:0]     CNT_LOAD = 3'(FP_LAT + 3);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_RD, S_RDW, S_FPR, S_FPI, S_FPW, S_WR
    } state_t;

    typedef struct packed {
        logic             remove;
        logic [FW-1:0]    re;
        logic [FW-1:0]    im;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } rec_t;

    // Target order for a branch: (r,r), (c,c), (r,c), (c,r). Shunts use only index 0.
    function automatic logic [IDX_W-1:0] tgt_row(input logic [1:0] k,
                                                  input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
        return (k == 2'd1 || k == 2'd3) ? c : r;
    endfunction

    function automatic logic [IDX_W-1:0] tgt_col(input logic [1:0] k,
                                                  input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
        return (k == 2'd1 || k == 2'd2) ? c : r;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] t,
                                                   input logic [IDX_W-1:0] u);
        return ADDR_W'(t) * ADDR_W'(WPR) + ADDR_W'(u >> LOG2L);
    endfunction

    // ---------------- record FIFO ----------------
    rec_t             fifo_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push, pop;
    rec_t             head;

    assign head         = fifo_q[rd_ptr_q];
    assign bus.in_ready = (count_q != FULL_CNT) && !reset;
    assign push         = bus.in_valid && bus.in_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{remove: bus.in_remove, re: bus.in_real, im: bus.in_img,
                                  row: bus.in_row, col: bus.in_col};
        end
    end

    // ---------------- engine ----------------
    state_t            state_q, state_d;
    rec_t              rec_q, rec_d;
    logic [1:0]        tgt_q, tgt_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [FW-1:0]     old_im_q, old_im_d;
    logic [FW-1:0]     res_re_q, res_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;
    logic [EW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [LANES-1:0]  lane_oh_q, lane_oh_d;
    logic [FW-1:0]     fp_in1_q, fp_in1_d, fp_in2_q, fp_in2_d;
    logic              fp_mode_q, fp_mode_d;
    logic              busy_q, busy_d, idle_q, idle_d;
    logic              rec_done_q, rec_done_d, err_q, err_d;
    logic [15:0]       rec_count_q, rec_count_d;

    logic              issue_rd;
    logic [IDX_W-1:0]  rd_t, rd_u;
    logic [IDX_W-1:0]  cur_u;
    logic [LOG2L-1:0]  cur_lane;
    logic              cur_mode, cur_last, bad_idx;
    logic [EW-1:0]     lane_word;

    assign cur_u    = tgt_col(tgt_q, rec_q.row, rec_q.col);
    assign cur_lane = cur_u[LOG2L-1:0];
    // Diagonal targets (0,1) add, off-diagonal (2,3) subtract; removal flips both.
    assign cur_mode = tgt_q[1] ^ rec_q.remove;
    assign cur_last = (rec_q.row == rec_q.col) ? (tgt_q == 2'd0) : (tgt_q == 2'd3);
    assign bad_idx  = (33'(head.row) >= N_EXT) || (33'(head.col) >= N_EXT);

    always_comb begin
        lane_word = '0;
        for (int k = 0; k < LANES; k++) begin
            if (cur_lane == LOG2L'(k)) lane_word = bus.mem_rdata[k*EW +: EW];
        end
    end

    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        tgt_d       = tgt_q;
        cnt_d       = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        old_im_d    = old_im_q;
        res_re_d    = res_re_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_we_d    = 1'b0;
        lane_oh_d   = '0;
        fp_in1_d    = '0;
        fp_in2_d    = '0;
        fp_mode_d   = 1'b0;
        rec_done_d  = 1'b0;
        err_d       = 1'b0;
        rec_count_d = rec_count_q;
        pop         = 1'b0;
        issue_rd    = 1'b0;
        rd_t        = '0;
        rd_u        = '0;

        // cnt runs down from FP_LAT+3 in RDW: 2 marks the real result, 1 the imag result.
        if ((state_q == S_FPI || state_q == S_FPW) && cnt_q == 3'd2) res_re_d = bus.fp_out;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && enable) state_d = S_POP;
            end
            S_POP: begin
                pop   = 1'b1;
                rec_d = head;
                if (bad_idx) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tgt_d    = 2'd0;
                    issue_rd = 1'b1;
                    rd_t     = head.row;
                    rd_u     = head.row;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                cnt_d   = CNT_LOAD;
                state_d = S_RDW;
            end
            S_RDW: begin
                old_im_d  = lane_word[FW-1:0];
                fp_in1_d  = lane_word[EW-1 -: FW];
                fp_in2_d  = rec_q.re;
                fp_mode_d = cur_mode;
                state_d   = S_FPR;
            end
            S_FPR: begin
                fp_in1_d  = old_im_q;
                fp_in2_d  = rec_q.im;
                fp_mode_d = cur_mode;
                state_d   = S_FPI;
            end
            S_FPI: begin
                state_d = S_FPW;
            end
            S_FPW: begin
                if (cnt_q == 3'd1) begin
                    mem_we_d    = 1'b1;
                    lane_oh_d   = LANES'(1) << cur_lane;
                    mem_wdata_d = {res_re_q, bus.fp_out};
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (cur_last) begin
                    rec_done_d  = 1'b1;
                    rec_count_d = rec_count_q + 16'd1;
                    state_d     = S_IDLE;
                end else begin
                    tgt_d    = tgt_q + 2'd1;
                    issue_rd = 1'b1;
                    rd_t     = tgt_row(tgt_q + 2'd1, rec_q.row, rec_q.col);
                    rd_u     = tgt_col(tgt_q + 2'd1, rec_q.row, rec_q.col);
                    state_d  = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue_rd) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_of(rd_t, rd_u);
        end

        busy_d = (state_d != S_IDLE);
        idle_d = (state_d == S_IDLE) && (count_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rec_q       <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            old_im_q    <= '0;
            res_re_q    <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            lane_oh_q   <= '0;
            fp_in1_q    <= '0;
            fp_in2_q    <= '0;
            fp_mode_q   <= 1'b0;
            busy_q      <= 1'b0;
            idle_q      <= 1'b1;
            rec_done_q  <= 1'b0;
            err_q       <= 1'b0;
            rec_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            old_im_q    <= old_im_d;
            res_re_q    <= res_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            lane_oh_q   <= lane_oh_d;
            fp_in1_q    <= fp_in1_d;
            fp_in2_q    <= fp_in2_d;
            fp_mode_q   <= fp_mode_d;
            busy_q      <= busy_d;
            idle_q      <= idle_d;
            rec_done_q  <= rec_done_d;
            err_q       <= err_d;
            rec_count_q <= rec_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Strobes are masked by reset so no access leaks out in the cycle reset is raised.
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = mem_rd_q & ~reset;
    assign bus.mem_we      = mem_we_q & ~reset;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_lane_oh = reset ? '0 : lane_oh_q;
    assign bus.fp_in1      = fp_in1_q;
    assign bus.fp_in2      = fp_in2_q;
    assign bus.fp_mode     = fp_mode_q;
    assign busy            = busy_q;
    assign idle            = idle_q;
    assign rec_done        = rec_done_q;
    assign err_range       = err_q;
    assign rec_count       = rec_count_q;
endmodule

// File: tb/tb_y_update_engine.sv
// Directed bench for y_update_engine with an SRAM model, an FP unit stand-in and a
// write scoreboard. The FP stand-in treats values as fixed point with 16 fraction
// bits, so 1.0 = 24'h010000 and 0.5 = 24'h008000.
module tb_y_update_engine;
    localparam int FW = 24, N = 64, LANES = 4, IDX_W = 16, ADDR_W = 10, DEPTH = 8, FP_LAT = 1;
    localparam logic [FW-1:0] ZERO = 24'h000000, HALF = 24'h008000, ONE = 24'h010000;
    localparam logic [FW-1:0] ONE_HALF = 24'h018000, TWO = 24'h020000;
    localparam logic [LANES*2*FW-1:0] PRELOAD = {LANES{ONE, ONE}};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        busy, idle, rec_done, err_range;
    logic [15:0] rec_count;

    y_update_engine_if #(.FW(FW), .LANES(LANES), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    y_update_engine #(.FW(FW), .N(N), .LANES(LANES), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
                      .DEPTH(DEPTH), .FP_LAT(FP_LAT)) dut (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus.master),
        .busy(busy), .idle(idle), .rec_done(rec_done), .err_range(err_range),
        .rec_count(rec_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LANES-1:0]  oh;
        logic [2*FW-1:0]   data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    // SRAM and FP unit models
    logic [LANES*2*FW-1:0] sram [N*N/LANES] = '{default: PRELOAD};

    always @(posedge clock) begin
        if (bus.mem_rd) bus.mem_rdata <= sram[bus.mem_addr];
        if (bus.mem_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.mem_lane_oh[k]) sram[bus.mem_addr][k*2*FW +: 2*FW] <= bus.mem_wdata;
            end
        end
        bus.fp_out <= bus.fp_mode ? bus.fp_in1 - bus.fp_in2 : bus.fp_in1 + bus.fp_in2;
    end

    // Write monitor / scoreboard
    always @(negedge clock) begin
        if (bus.mem_rd) rd_cnt++;
        if (bus.mem_we) begin
            wr_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr %0d lane_oh %b data %h, no write required",
                         bus.mem_addr, bus.mem_lane_oh, bus.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_lane_oh, bus.mem_wdata} !== mon_e) begin
                    miscompares++;
                    $display("FAIL write: got addr %0d oh %b data %h, required addr %0d oh %b data %h",
                             bus.mem_addr, bus.mem_lane_oh, bus.mem_wdata,
                             mon_e.addr, mon_e.oh, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic exp_wr(input int a, input logic [LANES-1:0] oh,
                          input logic [FW-1:0] re, input logic [FW-1:0] im);
        wr_t w;
        w.addr = ADDR_W'(a);
        w.oh   = oh;
        w.data = {re, im};
        exp_q.push_back(w);
    endtask

    task automatic push_rec(input int r, input int c, input logic [FW-1:0] re,
                            input logic [FW-1:0] im, input logic rm);
        int n;
        @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.in_row    = IDX_W'(r);
        bus.in_col    = IDX_W'(c);
        bus.in_real   = re;
        bus.in_img    = im;
        bus.in_remove = rm;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) timeout("push_accept");
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    // Returns at the rec_done cycle; the POP cycle is the first one with busy high.
    task automatic run_latency(input string name, input int req_lat);
        int n;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!busy) begin
            timeout({name, "_start"});
        end else begin
            n = 0;
            while (!rec_done && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (!rec_done) timeout(name);
            else chk(name, 64'(n), 64'(req_lat));
        end
    endtask

    localparam int T5_ADDR [8] = '{162, 178, 195, 211, 227, 243, 260, 276};
    localparam logic [3:0] T5_OH [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                         4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        int rd0, wr0, n, done_n;
        bus.in_valid = 1'b0; bus.in_row = '0; bus.in_col = '0;
        bus.in_real = '0; bus.in_img = '0; bus.in_remove = 1'b0;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_mem_addr", 64'(bus.mem_addr), 0);
        chk("rst_strobes", 64'({bus.mem_rd, bus.mem_we, bus.mem_lane_oh}), 0);
        chk("rst_fp", 64'({bus.fp_in1, bus.fp_in2, bus.fp_mode}), 0);
        chk("rst_rec_count", 64'(rec_count), 0);
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        chk("in_ready_after_rst", 64'(bus.in_ready), 1);

        // branch add (2,5) dY = 1.0 + j0.5 on a 1.0 + j1.0 matrix
        exp_wr(32, 4'b0100, TWO,  ONE_HALF);
        exp_wr(81, 4'b0010, TWO,  ONE_HALF);
        exp_wr(33, 4'b0010, ZERO, HALF);
        exp_wr(80, 4'b0100, ZERO, HALF);
        rd0 = rd_cnt;
        push_rec(2, 5, ONE, HALF, 1'b0);
        run_latency("lat_branch", 25);
        chk("rec_count_1", 64'(rec_count), 1);
        chk("branch_reads", 64'(rd_cnt - rd0), 4);

        // same branch removed: entries restored
        exp_wr(32, 4'b0100, ONE, ONE);
        exp_wr(81, 4'b0010, ONE, ONE);
        exp_wr(33, 4'b0010, ONE, ONE);
        exp_wr(80, 4'b0100, ONE, ONE);
        push_rec(2, 5, ONE, HALF, 1'b1);
        run_latency("lat_remove", 25);
        chk("rec_count_2", 64'(rec_count), 2);

        // shunt (7,7)
        exp_wr(113, 4'b1000, TWO, ONE_HALF);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        push_rec(7, 7, ONE, HALF, 1'b0);
        run_latency("lat_shunt", 7);
        @(negedge clock);
        chk("shunt_reads", 64'(rd_cnt - rd0), 1);
        chk("shunt_writes", 64'(wr_cnt - wr0), 1);
        chk("rec_count_3", 64'(rec_count), 3);

        // fill the FIFO while disabled
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_wr(T5_ADDR[i], T5_OH[i], TWO, ONE_HALF);
            push_rec(10 + i, 10 + i, ONE, HALF, 1'b0);
        end
        chk("full_in_ready", 64'(bus.in_ready), 0);
        chk("held_busy", 64'(busy), 0);
        chk("held_idle", 64'(idle), 0);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_row   = 16'd18;
        bus.in_col   = 16'd18;
        repeat (3) @(negedge clock);
        chk("ninth_blocked", 64'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        enable = 1'b1;
        n = 0;
        done_n = 0;
        while (done_n < 8 && n < 1000) begin
            @(negedge clock);
            n++;
            if (rec_done) done_n++;
        end
        chk("drain_done", 64'(done_n), 8);
        @(negedge clock);
        chk("drain_idle", 64'(idle), 1);
        chk("rec_count_11", 64'(rec_count), 11);

        // out-of-range row
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        push_rec(N, 3, ONE, HALF, 1'b0);
        n = 0;
        while (!err_range && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("err_range_pulse", 64'(err_range), 1);
        repeat (5) @(negedge clock);
        chk("err_no_access", 64'({rd_cnt - rd0, wr_cnt - wr0}), 0);
        chk("err_rec_count", 64'(rec_count), 11);

        // reset during FPW of the first target, with a second record queued
        wr0 = wr_cnt;
        enable = 1'b0;
        push_rec(20, 21, ONE, HALF, 1'b0);
        push_rec(22, 23, ONE, HALF, 1'b0);
        enable = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!busy) timeout("abort_start");
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 0);
        @(negedge clock);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_idle", 64'(idle), 1);
        chk("abort_mem_addr", 64'(bus.mem_addr), 0);
        chk("abort_outputs", 64'({bus.mem_we, bus.mem_lane_oh, bus.fp_mode, bus.fp_in1}), 0);
        chk("abort_wdata", 64'(bus.mem_wdata), 0);
        chk("abort_rec_count", 64'(rec_count), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("abort_no_write", 64'(wr_cnt - wr0), 0);
        chk("abort_fifo_flushed", 64'({busy, idle}), 1);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end
endmodule
